// File: rtl/run_det_pkg.sv
// Shared types for the run-length detector: output mode and FSM state encodings.
// No logic, no latency.
// No flow control; types only.
package run_det_pkg;

    typedef enum logic [1:0] {
        STICKY      = 2'b00,
        LEVEL       = 2'b01,
        PULSE_OVL   = 2'b10,
        PULSE_REARM = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FULL = 2'b10,
        S_LOCK = 2'b11
    } state_e;

endpackage

// File: rtl/run_detector_if.sv
// Control/observation bundle between a stimulus source and the run detector.
// Pure wiring, zero latency.
// No backpressure: the detector samples whenever en is high.
interface run_detector_if
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int HIT_W   = 8
);
    localparam int CNT_W = $clog2(RUN_LEN + 1);

    logic             en;
    logic             inp;
    logic             clr;
    mode_e            mode;
    logic             outp;
    logic [CNT_W-1:0] run_cnt;
    logic [HIT_W-1:0] hit_cnt;

    modport master (
        output en, inp, clr, mode,
        input  outp, run_cnt, hit_cnt
    );

    modport slave (
        input  en, inp, clr, mode,
        output outp, run_cnt, hit_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clr zeroes it and wins over inc.
// New value visible one edge after inc/clr.
// No backpressure; increments beyond MAX are silently dropped.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/run_detector.sv
// Flags RUN_LEN consecutive enabled 1s; sticky, level, pulse-overlap or pulse-rearm output.
// run_cnt/hit_cnt update on the hit edge; outp follows one edge later.
// No backpressure: en qualifies samples, disabled cycles hold the run.
module run_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int HIT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    run_detector_if.slave  bus
);
    localparam int               CNT_W   = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] RUN_HIT = CNT_W'(RUN_LEN - 1);

    state_e           state_q;
    state_e           state_d;
    logic             hit_q;
    logic             hit_d;
    logic             outp_q;
    logic             outp_d;
    logic [CNT_W-1:0] run_cnt;
    logic [HIT_W-1:0] hit_cnt;

    logic run_inc;
    logic run_zero;
    logic hit_inc;

    // Live run length; zeroing (0 sample, clr, rearm) beats incrementing.
    sat_counter #(
        .W   (CNT_W),
        .MAX (RUN_MAX)
    ) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .inc (run_inc),
        .clr (run_zero),
        .cnt (run_cnt)
    );

    // Detection event count survives clr; only rst zeroes it.
    sat_counter #(
        .W (HIT_W)
    ) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_inc),
        .clr (1'b0),
        .cnt (hit_cnt)
    );

    // Next state, hit event and output, all derived from current state and inputs.
    always_comb begin
        state_d  = state_q;
        hit_d    = 1'b0;
        run_inc  = 1'b0;
        run_zero = 1'b0;
        hit_inc  = 1'b0;
        outp_d   = 1'b0;

        // Output reflects the registered state every edge, enabled or not.
        unique case (bus.mode)
            STICKY:  outp_d = (state_q == S_LOCK);
            LEVEL:   outp_d = (state_q == S_FULL);
            default: outp_d = hit_q;
        endcase

        if (bus.clr) begin
            // Soft clear discards any coincident sample.
            state_d  = S_IDLE;
            run_zero = 1'b1;
            outp_d   = 1'b0;
        end else if (bus.en && (state_q != S_LOCK)) begin
            if (!bus.inp) begin
                run_zero = 1'b1;
                state_d  = S_IDLE;
            end else if (run_cnt == RUN_HIT) begin
                hit_d   = 1'b1;
                hit_inc = 1'b1;
                run_inc = 1'b1;
                unique case (bus.mode)
                    STICKY: state_d = S_LOCK;
                    PULSE_REARM: begin
                        run_zero = 1'b1;
                        state_d  = S_IDLE;
                    end
                    default: state_d = S_FULL;
                endcase
            end else if (run_cnt == RUN_MAX) begin
                // Already full: further 1s hold without a new event.
                state_d = S_FULL;
            end else begin
                run_inc = 1'b1;
                state_d = S_RUN;
            end
        end
    end

    // State, event flag and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hit_q   <= 1'b0;
            outp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            outp_q  <= outp_d;
        end
    end

    assign bus.outp    = outp_q;
    assign bus.run_cnt = run_cnt;
    assign bus.hit_cnt = hit_cnt;

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised run-length detector. It watches a serial input and flags when `RUN_LEN` consecutive qualified 1s have been sampled, with four selectable output modes: sticky, level, pulse-overlap and pulse-rearm. It also exports the live run count and a saturating count of detection events. It is a drop-in successor to the fixed three-in-a-row sticky detector in the control/sequence-detection path.

## Interface
Parameters:
- `RUN_LEN`, default 3: required run length; legal range ≥1.
- `HIT_W`, default 8: width of the hit event counter.
- `CNT_W`, derived localparam `$clog2(RUN_LEN+1)`: width of the run counter. Not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: synchronous, active-high. Clears all state and outputs at the next rising edge.
- `en`  in  1  sample qualifier. `inp` is consumed only on edges where `en`=1.
- `inp`  in  1  serial data bit.
- `clr`  in  1  synchronous soft clear. Clears everything except `hit_cnt`.
- `mode`  in  2  00 STICKY, 01 LEVEL, 10 PULSE_OVL, 11 PULSE_REARM.
- `outp`  out  1  registered detection output.
- `run_cnt`  out  `CNT_W`  current run length, 0..`RUN_LEN`.
- `hit_cnt`  out  `HIT_W`  number of detection events, saturating at all-ones.

## Operation
- **Internal registers:** `run_cnt`, state, `hit_q` (detection event flag), `outp`, `hit_cnt`.
- **States:**
  - S_IDLE: `run_cnt`=0.
  - S_RUN: 0<`run_cnt`<`RUN_LEN`.
  - S_FULL: `run_cnt`=`RUN_LEN`, non-sticky modes only.
  - S_LOCK: sticky detection latched.
- **Enabled edge with `inp`=0:** `run_cnt`←0 and state→S_IDLE. Exception: S_LOCK holds.
- **Enabled edge with `inp`=1:** `run_cnt` increments, saturating at `RUN_LEN`.
- **Hit event:** an enabled edge with `inp`=1 and `run_cnt`=`RUN_LEN`-1. The event sets `hit_q` for exactly one cycle and increments `hit_cnt`, saturating.
- **Per-mode behaviour on a hit:**
  - STICKY: state→S_LOCK. `inp` is ignored until `rst`/`clr`. No further hits.
  - LEVEL: state→S_FULL. Further 1s hold S_FULL without new hits. A 0 returns to S_IDLE.
  - PULSE_OVL: same state behaviour as LEVEL.
  - PULSE_REARM: `run_cnt`←0 and state→S_IDLE on the hit edge, so every further `RUN_LEN` ones produce a new hit.
- **`outp` (registered from the current state, evaluated every edge regardless of `en`):**
  - STICKY: `outp`=(state==S_LOCK).
  - LEVEL: `outp`=(state==S_FULL).
  - PULSE modes: `outp`=`hit_q`.
- **`en`=0:** `run_cnt`, state and `hit_cnt` hold. `hit_q` clears. A run is not broken by disabled cycles.
- **`clr`:** `run_cnt`, state, `hit_q` and `outp` go to 0/S_IDLE. It overrides a simultaneous `en`&`inp`, and that sample is discarded.
- **Priority:** `rst` > `clr` > sample.
- **`mode` changes:** legal only together with `rst` or `clr`. A change at any other time has an undefined `outp` for one cycle but must not corrupt `hit_cnt`.
- **`RUN_LEN`=1:** every enabled 1 is a hit in PULSE_REARM. LEVEL and PULSE_OVL hit on the first 1 after a 0.

## Timing
- **Reset values:** `outp`=0, `run_cnt`=0, `hit_cnt`=0, state S_IDLE, `hit_q`=0.
- **Hit latency:**
  - `run_cnt` and `hit_cnt` update on the hit edge (edge N).
  - `outp` rises at edge N+1.
  - Pulses are exactly 1 cycle wide.
- **LEVEL deassert:** `outp` falls one edge after the edge that samples a 0.
- **`clr`/`rst` to `outp`=0:** one edge.

## Structure
- Package `run_det_pkg`: `mode_e` enum (STICKY, LEVEL, PULSE_OVL, PULSE_REARM), `state_e` enum (S_IDLE, S_RUN, S_FULL, S_LOCK).
- Sub-module `sat_counter` (parameter `W`; ports inc, clr, cnt). Instantiated for `hit_cnt`. `run_cnt` also uses it, with a max-value parameter of `RUN_LEN`.

## Test plan
Defaults `RUN_LEN`=3, `HIT_W`=4, `en`=1 unless stated.
- **STICKY:** `rst`, then `inp` 1,1,1 → `run_cnt`=3 after edge 3, `outp`=1 after edge 4. `outp` stays 1 through 10 zeros. `clr` → `outp`=0 next edge, `hit_cnt`=1.
- **LEVEL:** `inp` 1,1,0,1,1,1,1,0 → `run_cnt` 1,2,0,1,2,3,3,0. `outp`=1 only after edges 7 and 8. `hit_cnt`=1.
- **PULSE_REARM:** 7 ones → hits at edges 3 and 6, `outp`=1 only after edges 4 and 7, `hit_cnt`=2, final `run_cnt`=1.
- **PULSE_OVL:** 7 ones → single `outp` pulse after edge 4, `hit_cnt`=1, `run_cnt` holds 3.
- **`en` gaps:** in LEVEL, `inp`=1 with `en` pattern 1,0,0,1,0,1 → hit on the 6th edge. `run_cnt` holds during `en`=0.
- **Saturation and abort:** 20 PULSE_REARM hits → `hit_cnt`=15. Then `rst` mid-run with `inp`=1 → all outputs 0 next edge. Also `clr` asserted together with the 3rd 1 → no hit, `run_cnt`=0.
